// File: rtl/regfile_mp_pkg.sv
// Shared defaults and port-slice helper for the multi-port register file.
// Latency: n/a. Backpressure: n/a.
`ifndef REGFILE_MP_PKG_SV
`define REGFILE_MP_PKG_SV

// Slice of port k out of a packed vector of w-bit fields.
`define RF_SLICE(k, w) (k)*(w) +: (w)

package regfile_mp_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_REG   = 0;
endpackage

`endif

// File: rtl/regfile_mp_if.sv
// Read/write/issue bundle between the pipeline and the register file.
// Latency: n/a. Backpressure: none, every port is accepted every cycle.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
);
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic [NUM_RD-1:0]        rd_pend;
  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] wa;
  logic [NUM_WR*DATA_W-1:0] wd;
  logic                     iss_v;
  logic [ADDR_W-1:0]        iss_dst;

  modport master (output ra, we, wa, wd, iss_v, iss_dst, input rd, rd_pend);
  modport slave  (input ra, we, wa, wd, iss_v, iss_dst, output rd, rd_pend);
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write bit per register; issue sets, writeback clears, issue wins on a tie.
// Latency: rd_pend combinational from ra. Backpressure: none.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_WR = 1,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        i_we,
  input  logic [NUM_WR*ADDR_W-1:0] i_wa,
  input  logic                     i_iss_v,
  input  logic [ADDR_W-1:0]        i_iss_dst,
  input  logic [NUM_RD*ADDR_W-1:0] i_ra,
  output logic [NUM_RD-1:0]        o_rd_pend
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_wr_hit;
  logic [DEPTH-1:0] w_set;

  always_comb begin
    w_wr_hit = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (i_we[j] && i_wa[`RF_SLICE(j, ADDR_W)] != ADDR_W'(ZERO_REG))
        w_wr_hit[i_wa[`RF_SLICE(j, ADDR_W)]] = 1'b1;
    end
  end

  always_comb begin
    w_set = '0;
    if (i_iss_v && i_iss_dst != ADDR_W'(ZERO_REG))
      w_set[i_iss_dst] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) r_pend <= '0;
    else       r_pend <= (r_pend & ~w_wr_hit) | w_set;
  end

  // A same-cycle bypassed write already satisfies the consumer.
  always_comb begin
    o_rd_pend = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (i_ra[`RF_SLICE(k, ADDR_W)] != ADDR_W'(ZERO_REG))
        o_rd_pend[k] = r_pend[i_ra[`RF_SLICE(k, ADDR_W)]] &
                       ~((BYPASS != 0) && !reset && w_wr_hit[i_ra[`RF_SLICE(k, ADDR_W)]]);
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass and hazard scoreboard.
// Latency: reads combinational; writes visible next cycle (same cycle with bypass). Backpressure: none.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int BYPASS = 1
) (
  input logic         clk,
  input logic         reset,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Descending port order so port 0, issued last, wins a same-address conflict.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int j = NUM_WR - 1; j >= 0; j--) begin
        if (bus.we[j] && bus.wa[`RF_SLICE(j, ADDR_W)] != ADDR_W'(ZERO_REG))
          r_mem[bus.wa[`RF_SLICE(j, ADDR_W)]] <= bus.wd[`RF_SLICE(j, DATA_W)];
      end
    end
  end

  always_comb begin
    bus.rd = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (bus.ra[`RF_SLICE(k, ADDR_W)] != ADDR_W'(ZERO_REG)) begin
        bus.rd[`RF_SLICE(k, DATA_W)] = r_mem[bus.ra[`RF_SLICE(k, ADDR_W)]];
        if ((BYPASS != 0) && !reset) begin
          for (int j = NUM_WR - 1; j >= 0; j--) begin
            if (bus.we[j] && bus.wa[`RF_SLICE(j, ADDR_W)] == bus.ra[`RF_SLICE(k, ADDR_W)])
              bus.rd[`RF_SLICE(k, DATA_W)] = bus.wd[`RF_SLICE(j, DATA_W)];
          end
        end
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR),
    .NUM_RD (NUM_RD),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .i_we      (bus.we),
    .i_wa      (bus.wa),
    .i_iss_v   (bus.iss_v),
    .i_iss_dst (bus.iss_dst),
    .i_ra      (bus.ra),
    .o_rd_pend (bus.rd_pend)
  );
endmodule
